io_responder: RTL and testbench

Peripheral-side responder for the processor's word-wide I/O handshakes. It answers `out_req` by capturing `out_data` into a TX FIFO and pulsing `out_ack`. It answers `inp_req` by popping an RX FIFO onto `inp_data` and pulsing `inp_ack`. The block sits between the CPU I/O ports and an external stream device, which drains TX and fills RX over valid/ready.

---
 rtl/io_responder_if.sv | 61 ++++++
 rtl/io_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_io_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_responder_if.sv
// io_responder bus bundle: CPU request/ack ports plus
// the device-side TX/RX stream ports and occupancy.
interface io_responder_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             out_req;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;

    logic             inp_req;
    logic [WIDTH-1:0] inp_data;
    logic             inp_ack;

    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;

    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_ready;

    logic [CW-1:0]    tx_count;
    logic [CW-1:0]    rx_count;

    modport slave (
        input  out_req,
        input  out_data,
        output out_ack,
        input  inp_req,
        output inp_data,
        output inp_ack,
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output tx_count,
        output rx_count
    );

    modport master (
        output out_req,
        output out_data,
        input  out_ack,
        output inp_req,
        input  inp_data,
        input  inp_ack,
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  tx_count,
        input  rx_count
    );
endinterface

// File: rtl/io_responder.sv
// io_responder: CPU I/O req/ack responder with TX/RX FIFOs.
// Optional TX->RX loopback when IO_RESP_LOOPBACK_EN is defined.
module io_responder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst_b,
`ifdef IO_RESP_LOOPBACK_EN
    input logic loopback,
`endif
    io_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        O_IDLE,
        O_ACK,
        O_WAIT
    } o_state_t;

    typedef enum logic [1:0] {
        I_IDLE,
        I_ACK,
        I_WAIT
    } i_state_t;

    o_state_t o_state;
    i_state_t i_state;

    logic [WIDTH-1:0] tx_mem [DEPTH];
    logic [WIDTH-1:0] rx_mem [DEPTH];

    logic [AW-1:0] tx_wptr;
    logic [AW-1:0] tx_rptr;
    logic [AW-1:0] rx_wptr;
    logic [AW-1:0] rx_rptr;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;

    logic             out_ack_q;
    logic             inp_ack_q;
    logic [WIDTH-1:0] inp_data_q;

    logic             tx_nempty;
    logic             tx_nfull;
    logic             rx_nempty;
    logic             rx_nfull;
    logic             tx_push;
    logic             tx_pop;
    logic             rx_push;
    logic             rx_pop;
    logic [WIDTH-1:0] tx_head;
    logic [WIDTH-1:0] rx_head;
    logic [WIDTH-1:0] rx_wdata;

    // Full/empty decisions all use the pre-edge counts.
    assign tx_nempty = (tx_cnt != '0);
    assign tx_nfull  = (tx_cnt != FULL);
    assign rx_nempty = (rx_cnt != '0);
    assign rx_nfull  = (rx_cnt != FULL);

    assign tx_head = tx_mem[tx_rptr];
    assign rx_head = rx_mem[rx_rptr];

    // CPU-side transfers are only taken from the idle states.
    assign tx_push = (o_state == O_IDLE)
                   && bus.out_req
                   && tx_nfull;
    assign rx_pop  = (i_state == I_IDLE)
                   && bus.inp_req
                   && rx_nempty;

`ifdef IO_RESP_LOOPBACK_EN
    logic lb_xfer;

    assign lb_xfer = tx_nempty && rx_nfull;

    assign tx_pop = loopback
                  ? lb_xfer
                  : (tx_nempty && bus.tx_ready);
    assign rx_push = loopback
                   ? lb_xfer
                   : (rx_nfull && bus.rx_valid);
    assign rx_wdata = loopback ? tx_head : bus.rx_data;

    assign bus.tx_valid = tx_nempty && !loopback;
    assign bus.rx_ready = rx_nfull && !loopback;
`else
    assign tx_pop   = tx_nempty && bus.tx_ready;
    assign rx_push  = rx_nfull && bus.rx_valid;
    assign rx_wdata = bus.rx_data;

    assign bus.tx_valid = tx_nempty;
    assign bus.rx_ready = rx_nfull;
`endif

    assign bus.tx_data  = tx_head;
    assign bus.tx_count = tx_cnt;
    assign bus.rx_count = rx_cnt;
    assign bus.out_ack  = out_ack_q;
    assign bus.inp_ack  = inp_ack_q;
    assign bus.inp_data = inp_data_q;

    // TX storage write; contents are not cleared on reset.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= bus.out_data;
        end
    end

    // RX storage write; contents are not cleared on reset.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= rx_wdata;
        end
    end

    // TX pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + 1'b1;
            end
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // RX pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + 1'b1;
            end
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Output FSM: one TX push and one ack pulse per request.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            o_state   <= O_IDLE;
            out_ack_q <= 1'b0;
        end else begin
            out_ack_q <= 1'b0;
            unique case (o_state)
                O_IDLE: begin
                    if (tx_push) begin
                        o_state   <= O_ACK;
                        out_ack_q <= 1'b1;
                    end
                end
                O_ACK: begin
                    o_state <= O_WAIT;
                end
                O_WAIT: begin
                    if (!bus.out_req) begin
                        o_state <= O_IDLE;
                    end
                end
                default: begin
                    o_state <= O_IDLE;
                end
            endcase
        end
    end

    // Input FSM: one RX pop per request, word held until next pop.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            i_state    <= I_IDLE;
            inp_ack_q  <= 1'b0;
            inp_data_q <= '0;
        end else begin
            inp_ack_q <= 1'b0;
            unique case (i_state)
                I_IDLE: begin
                    if (rx_pop) begin
                        i_state    <= I_ACK;
                        inp_ack_q  <= 1'b1;
                        inp_data_q <= rx_head;
                    end
                end
                I_ACK: begin
                    i_state <= I_WAIT;
                end
                I_WAIT: begin
                    if (!bus.inp_req) begin
                        i_state <= I_IDLE;
                    end
                end
                default: begin
                    i_state <= I_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: queue-based model
// compared every cycle, plus directed literal checks.
module tb_io_responder;
    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_b;
    logic loopback;

    io_responder_if #(.WIDTH(W), .DEPTH(D)) bus ();

    io_responder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
`ifdef IO_RESP_LOOPBACK_EN
        .loopback (loopback),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic bit lb_now();
`ifdef IO_RESP_LOOPBACK_EN
        return loopback;
`else
        return 1'b0;
`endif
    endfunction

    // Behavioural model: two word queues and per-direction
    // request bookkeeping (ack pending / waiting for release).
    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    bit           m_oack, m_ohold;
    bit           m_iack, m_ihold;
    logic [W-1:0] m_idata;
    int           m_tn, m_rn;
    bit           m_lb, m_tpop, m_tpush, m_rpush, m_rpop;
    logic [W-1:0] m_rin;

    always begin
        @(posedge clk);
        if (rst_b) begin
            txq.delete();
            rxq.delete();
            m_oack  = 1'b0;
            m_ohold = 1'b0;
            m_iack  = 1'b0;
            m_ihold = 1'b0;
            m_idata = '0;
        end else begin
            m_tn = txq.size();
            m_rn = rxq.size();
            m_lb = lb_now();
            if (m_lb) begin
                m_tpop  = (m_tn > 0) && (m_rn < D);
                m_rpush = m_tpop;
                m_rin   = m_tpop ? txq[0] : '0;
            end else begin
                m_tpop  = (m_tn > 0) && bus.tx_ready;
                m_rpush = (m_rn < D) && bus.rx_valid;
                m_rin   = bus.rx_data;
            end
            m_tpush = 1'b0;
            if (m_oack) begin
                m_oack  = 1'b0;
                m_ohold = 1'b1;
            end else if (m_ohold) begin
                if (!bus.out_req) m_ohold = 1'b0;
            end else if (bus.out_req && (m_tn < D)) begin
                m_tpush = 1'b1;
                m_oack  = 1'b1;
            end
            m_rpop = 1'b0;
            if (m_iack) begin
                m_iack  = 1'b0;
                m_ihold = 1'b1;
            end else if (m_ihold) begin
                if (!bus.inp_req) m_ihold = 1'b0;
            end else if (bus.inp_req && (m_rn > 0)) begin
                m_rpop = 1'b1;
                m_iack = 1'b1;
            end
            if (m_tpop) void'(txq.pop_front());
            if (m_tpush) txq.push_back(bus.out_data);
            if (m_rpop) m_idata = rxq.pop_front();
            if (m_rpush) rxq.push_back(m_rin);
        end
        #1;
        m_lb = lb_now();
        chk("out_ack", bus.out_ack, m_oack);
        chk("inp_ack", bus.inp_ack, m_iack);
        chk("inp_data", bus.inp_data, m_idata);
        chk("tx_count", bus.tx_count, txq.size());
        chk("rx_count", bus.rx_count, rxq.size());
        chk("tx_valid", bus.tx_valid,
            !m_lb && (txq.size() > 0));
        chk("rx_ready", bus.rx_ready,
            !m_lb && (rxq.size() < D));
        if (txq.size() > 0) begin
            chk("tx_data", bus.tx_data, txq[0]);
        end
    end

    // Callers sit on a negedge; returns on a negedge.
    task automatic send_word(input logic [W-1:0] w);
        bit ok;
        ok = 1'b0;
        bus.out_req  = 1'b1;
        bus.out_data = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_ack) ok = 1'b1;
        end
        chk("send_ack_seen", ok, 1'b1);
        bus.out_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic recv_word(output logic [W-1:0] w);
        bit ok;
        ok = 1'b0;
        w  = '0;
        bus.inp_req = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.inp_ack) begin
                ok = 1'b1;
                w  = bus.inp_data;
            end
        end
        chk("recv_ack_seen", ok, 1'b1);
        bus.inp_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        int  pulses;
        int  first;
        bit  ok;
        bit  o_done, i_done;

        rst_b        = 1'b1;
        loopback     = 1'b0;
        bus.out_req  = 1'b0;
        bus.out_data = '0;
        bus.inp_req  = 1'b0;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);

        // Reset asserted while the output FSM is acking.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h00A5;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        recv_word(w);
        chk("pre_reset_rx", w, 16'h00A5);
        bus.out_req  = 1'b1;
        bus.out_data = 16'h5A5A;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_ack) ok = 1'b1;
        end
        chk("pre_reset_ack", ok, 1'b1);
        #2;
        rst_b = 1'b1;
        #1;
        chk("rst_out_ack", bus.out_ack, 1'b0);
        chk("rst_tx_count", bus.tx_count, 0);
        chk("rst_inp_data", bus.inp_data, 16'h0000);
        chk("rst_rx_ready", bus.rx_ready, 1'b1);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        bus.out_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);

        // Single output, request held four cycles.
        bus.out_data = 16'hBEEF;
        bus.out_req  = 1'b1;
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.out_ack) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i == 4) bus.out_req = 1'b0;
        end
        chk("single_pulses", pulses, 1);
        chk("single_latency", first, 1);
        chk("single_tx_count", bus.tx_count, 1);
        chk("single_tx_data", bus.tx_data, 16'hBEEF);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        chk("single_drained", bus.tx_count, 0);

        // TX full: ninth word waits for one device pop.
        for (int v = 1; v <= 8; v++) send_word(16'(v));
        chk("full_tx_count", bus.tx_count, 8);
        bus.out_data = 16'd9;
        bus.out_req  = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_ack) pulses++;
        end
        chk("full_no_ack", pulses, 0);
        chk("full_head", bus.tx_data, 16'd1);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        chk("full_refused", bus.out_ack, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 5 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_ack) ok = 1'b1;
        end
        chk("full_ninth_ack", ok, 1'b1);
        bus.out_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("full_tx_count2", bus.tx_count, 8);
        bus.tx_ready = 1'b1;
        for (int v = 2; v <= 9; v++) begin
            chk("drain_valid", bus.tx_valid, 1'b1);
            chk("drain_order", bus.tx_data, 16'(v));
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
        chk("drain_empty", bus.tx_count, 0);

        // RX empty, then a single device push.
        bus.inp_req = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.inp_ack) pulses++;
        end
        chk("rx_empty_no_ack", pulses, 0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h1234;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("rx_fill_ack_early", bus.inp_ack, 1'b0);
        chk("rx_fill_count", bus.rx_count, 1);
        @(negedge clk);
        chk("rx_fill_ack", bus.inp_ack, 1'b1);
        chk("rx_fill_data", bus.inp_data, 16'h1234);
        bus.inp_req = 1'b0;
        @(negedge clk);
        chk("rx_fill_count0", bus.rx_count, 0);
        @(negedge clk);

        // Stream 20 words through RX across pointer wrap.
        fork
            begin
                int  k;
                bit  acc;
                k = 0;
                bus.rx_valid = 1'b1;
                bus.rx_data  = 16'h0100;
                for (int g = 0; g < 2000 && k < 20; g++) begin
                    acc = bus.rx_ready;
                    @(negedge clk);
                    if (acc) begin
                        k++;
                        if (k < 20) bus.rx_data = 16'(16'h0100 + k);
                        else bus.rx_valid = 1'b0;
                    end
                end
                bus.rx_valid = 1'b0;
                chk("wrap_pushed", k, 20);
            end
            begin
                logic [W-1:0] r;
                for (int j = 0; j < 20; j++) begin
                    recv_word(r);
                    chk("wrap_order", r, 16'(16'h0100 + j));
                end
            end
        join
        chk("wrap_empty", bus.rx_count, 0);

`ifdef IO_RESP_LOOPBACK_EN
        // Loopback: TX words come back through RX in order.
        loopback = 1'b1;
        @(negedge clk);
        for (int v = 1; v <= 3; v++) begin
            send_word(16'(v));
            chk("lb_tx_valid", bus.tx_valid, 1'b0);
        end
        for (int v = 1; v <= 3; v++) begin
            recv_word(w);
            chk("lb_data", w, 16'(v));
            chk("lb_tx_valid2", bus.tx_valid, 1'b0);
        end
        loopback = 1'b0;
        @(negedge clk);
`endif

        // Random traffic on both sides, checked by the model.
        o_done = 1'b0;
        i_done = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!bus.out_req) begin
                if ($urandom_range(3) == 0) begin
                    bus.out_req  = 1'b1;
                    bus.out_data = 16'($urandom);
                    o_done = 1'b0;
                end
            end else begin
                if (bus.out_ack) o_done = 1'b1;
                if (o_done && $urandom_range(1) == 0)
                    bus.out_req = 1'b0;
            end
            if (!bus.inp_req) begin
                if ($urandom_range(3) == 0) begin
                    bus.inp_req = 1'b1;
                    i_done = 1'b0;
                end
            end else begin
                if (bus.inp_ack) i_done = 1'b1;
                if (i_done && $urandom_range(1) == 0)
                    bus.inp_req = 1'b0;
            end
            bus.tx_ready = ($urandom_range(2) == 0);
            bus.rx_valid = ($urandom_range(2) == 0);
            bus.rx_data  = 16'($urandom);
`ifdef IO_RESP_LOOPBACK_EN
            if ($urandom_range(150) == 0) loopback = ~loopback;
`endif
            if (c == 2500) begin
                #2;
                rst_b = 1'b1;
                @(negedge clk);
                rst_b = 1'b0;
                bus.out_req = 1'b0;
                bus.inp_req = 1'b0;
            end
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
